// File: rtl/hbm_phy_pkg.sv
// Shared types and constants for the HBM PHY responder: FSM state encoding,
// command encoding and the byte-offset width of one 64-byte word.
package hbm_phy_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_BUSY = 2'd2,
        ERR     = 2'd3
    } state_e;

    localparam logic CMD_RD     = 1'b0;
    localparam logic CMD_WR     = 1'b1;
    localparam int   WORD_OFS_W = 6;
    localparam int   CNT_W      = 4;

endpackage

// File: rtl/hbm_phy_mem.sv
// DEPTH x DATA_W word array with a synchronous write and a registered read
// port; kept reset-free so it maps onto block RAM.
module hbm_phy_mem #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 512,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port: one word per enabled edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read port: registered, old data on the edge it is sampled.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/hbm_phy_responder.sv
// PHY-side responder: accepts one read/write at a time, applies a fixed
// access latency against an internal word array and returns data or an error.
module hbm_phy_responder
    import hbm_phy_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 512,
    parameter int DEPTH  = 64,
    parameter int WR_LAT = 2,
    parameter int RD_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              phy_cmd_valid,
    input  logic              phy_cmd,
    input  logic [ADDR_W-1:0] phy_addr,
    input  logic [DATA_W-1:0] phy_wr_data,
    output logic              phy_ready,
    output logic [DATA_W-1:0] phy_rd_data,
    output logic              phy_rd_valid,
    output logic              phy_error
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int UP_W  = ADDR_W - WORD_OFS_W;
    localparam logic [UP_W-1:0]  DEPTH_W   = UP_W'(DEPTH);
    localparam logic [CNT_W-1:0] WR_CNT0   = CNT_W'(WR_LAT - 1);
    localparam logic [CNT_W-1:0] RD_CNT0   = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ready_q;
    logic              rd_valid_q;
    logic              error_q;
    logic [DATA_W-1:0] rd_data_q;

    logic [UP_W-1:0]   word_s;
    logic              legal_s;
    logic              accept_s;
    logic              mem_we_s;
    logic              mem_re_s;
    logic [IDX_W-1:0]  mem_addr_s;
    logic [DATA_W-1:0] mem_rdata_s;

    // Address check and array port steering; the read is launched on the
    // accept edge so that RD_LAT=1 still has data ready at its completing edge.
    always_comb begin
        word_s   = phy_addr[ADDR_W-1:WORD_OFS_W];
        legal_s  = (phy_addr[WORD_OFS_W-1:0] == {WORD_OFS_W{1'b0}}) && (word_s < DEPTH_W);
        accept_s = phy_cmd_valid && ready_q;
        if (state_q == IDLE) begin
            mem_addr_s = word_s[IDX_W-1:0];
        end else begin
            mem_addr_s = idx_q;
        end
        mem_re_s = (accept_s && legal_s && (phy_cmd == CMD_RD)) || (state_q == RD_BUSY);
        mem_we_s = (state_q == WR_BUSY) && (cnt_q == CNT_ZERO);
    end

    // Command FSM, latency counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= CNT_ZERO;
            idx_q      <= {IDX_W{1'b0}};
            wdata_q    <= {DATA_W{1'b0}};
            ready_q    <= 1'b1;
            rd_valid_q <= 1'b0;
            error_q    <= 1'b0;
            rd_data_q  <= {DATA_W{1'b0}};
        end else begin
            rd_valid_q <= 1'b0;
            error_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        ready_q <= 1'b0;
                        idx_q   <= word_s[IDX_W-1:0];
                        wdata_q <= phy_wr_data;
                        if (!legal_s) begin
                            state_q <= ERR;
                            error_q <= 1'b1;
                        end else if (phy_cmd == CMD_WR) begin
                            state_q <= WR_BUSY;
                            cnt_q   <= WR_CNT0;
                        end else begin
                            state_q <= RD_BUSY;
                            cnt_q   <= RD_CNT0;
                        end
                    end
                end
                WR_BUSY: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                RD_BUSY: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_q    <= IDLE;
                        ready_q    <= 1'b1;
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= mem_rdata_s;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ERR: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    hbm_phy_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we_s),
        .re_i    (mem_re_s),
        .addr_i  (mem_addr_s),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata_s)
    );

    assign phy_ready    = ready_q;
    assign phy_rd_data  = rd_data_q;
    assign phy_rd_valid = rd_valid_q;
    assign phy_error    = error_q;

endmodule

// File: tb/tb_hbm_phy_responder.sv
// Directed bench for hbm_phy_responder with default parameters
// (DEPTH=64, WR_LAT=2, RD_LAT=4).
module tb_hbm_phy_responder;

    logic         clk;
    logic         reset;
    logic         phy_cmd_valid;
    logic         phy_cmd;
    logic [31:0]  phy_addr;
    logic [511:0] phy_wr_data;
    logic         phy_ready;
    logic [511:0] phy_rd_data;
    logic         phy_rd_valid;
    logic         phy_error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;

    hbm_phy_responder dut (
        .clk           (clk),
        .reset         (reset),
        .phy_cmd_valid (phy_cmd_valid),
        .phy_cmd       (phy_cmd),
        .phy_addr      (phy_addr),
        .phy_wr_data   (phy_wr_data),
        .phy_ready     (phy_ready),
        .phy_rd_data   (phy_rd_data),
        .phy_rd_valid  (phy_rd_valid),
        .phy_error     (phy_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for ready (bounded), present one command for a single edge.
    task automatic issue(input logic cmd, input logic [31:0] addr, input logic [511:0] data);
        int k;
        k = 0;
        while (!phy_ready && k < 50) begin
            tick();
            k++;
        end
        if (!phy_ready) chk("ready_timeout", 512'(phy_ready), 512'd1);
        phy_cmd_valid = 1'b1;
        phy_cmd       = cmd;
        phy_addr      = addr;
        phy_wr_data   = data;
        tick();
        phy_cmd_valid = 1'b0;
        acc_cyc       = cyc;
    endtask

    // Cycles after the accept edge until rd_valid is seen.
    task automatic wait_rdv(output int n);
        n = 0;
        while (!phy_rd_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    localparam logic [511:0] PAT = {16{32'hDEAD_BEEF}};
    localparam logic [511:0] W0  = {8{64'h0123_4567_89AB_CDEF}};
    localparam logic [511:0] DA  = {16{32'hAAAA_0002}};
    localparam logic [511:0] DB  = {16{32'hBBBB_0003}};

    initial begin
        int n;
        int prev;
        logic [511:0] d;
        logic saw;

        reset         = 1'b1;
        phy_cmd_valid = 1'b0;
        phy_cmd       = 1'b0;
        phy_addr      = 32'h0;
        phy_wr_data   = 512'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 512'(phy_ready), 512'd1);
        chk("rst_rdv", 512'(phy_rd_valid), 512'd0);
        chk("rst_err", 512'(phy_error), 512'd0);
        chk("rst_rdata", phy_rd_data, 512'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Write PAT to 0x40: ready low for exactly WR_LAT cycles.
        issue(1'b1, 32'h40, PAT);
        n = 0;
        while (!phy_ready && n < 20) begin
            n++;
            tick();
        end
        chk("wr_ready_low", 512'(n), 512'd2);

        // Read 0x40: rd_valid RD_LAT cycles after accept, ready high alongside.
        issue(1'b0, 32'h40, 512'h0);
        wait_rdv(n);
        chk("rd_latency", 512'(n), 512'd4);
        chk("rd_data", phy_rd_data, PAT);
        chk("rd_ready", 512'(phy_ready), 512'd1);
        tick();
        chk("rdv_one_cycle", 512'(phy_rd_valid), 512'd0);

        // Misaligned read at 0x41.
        issue(1'b0, 32'h41, 512'h0);
        chk("mis_err", 512'(phy_error), 512'd1);
        chk("mis_ready0", 512'(phy_ready), 512'd0);
        chk("mis_rdv0", 512'(phy_rd_valid), 512'd0);
        tick();
        chk("mis_err_drop", 512'(phy_error), 512'd0);
        chk("mis_ready1", 512'(phy_ready), 512'd1);
        chk("mis_rdv1", 512'(phy_rd_valid), 512'd0);
        chk("mis_rdata", phy_rd_data, PAT);

        // Out-of-range write at 0x1000 must not alias onto word 0.
        issue(1'b1, 32'h0, W0);
        issue(1'b1, 32'h1000, {16{32'hBAD0_BAD0}});
        chk("oor_err", 512'(phy_error), 512'd1);
        issue(1'b0, 32'h0, 512'h0);
        wait_rdv(n);
        chk("oor_word0", phy_rd_data, W0);

        // Second write held while busy is taken only once ready returns.
        issue(1'b1, 32'h80, DA);
        phy_cmd_valid = 1'b1;
        phy_cmd       = 1'b1;
        phy_addr      = 32'hC0;
        phy_wr_data   = DB;
        n = 0;
        while (!phy_ready && n < 20) begin
            tick();
            n++;
        end
        chk("hold_wait", 512'(n), 512'd2);
        tick();
        chk("hold_accept", 512'(phy_ready), 512'd0);
        phy_cmd_valid = 1'b0;
        issue(1'b0, 32'h80, 512'h0);
        wait_rdv(n);
        chk("hold_word2", phy_rd_data, DA);
        issue(1'b0, 32'hC0, 512'h0);
        wait_rdv(n);
        chk("hold_word3", phy_rd_data, DB);

        // Reset while RD_BUSY with cnt = 2 (one edge after accept).
        issue(1'b0, 32'h40, 512'h0);
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 512'(phy_ready), 512'd1);
        chk("mid_rst_rdv", 512'(phy_rd_valid), 512'd0);
        chk("mid_rst_err", 512'(phy_error), 512'd0);
        chk("mid_rst_rdata", phy_rd_data, 512'h0);
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (phy_rd_valid || phy_error || !phy_ready) saw = 1'b1;
        end
        chk("mid_rst_quiet", 512'(saw), 512'd0);

        // Sweep all 64 words.
        prev = 0;
        for (int i = 0; i < 64; i++) begin
            d = {16{32'h5A5A_0000 ^ 32'(i)}};
            issue(1'b1, 32'(i) << 6, d);
            if (i > 0) chk("wr_gap", 512'(acc_cyc - prev), 512'd3);
            prev = acc_cyc;
        end
        for (int i = 0; i < 64; i++) begin
            d = {16{32'h5A5A_0000 ^ 32'(i)}};
            issue(1'b0, 32'(i) << 6, 512'h0);
            if (i > 0) chk("rd_gap", 512'(acc_cyc - prev), 512'd5);
            prev = acc_cyc;
            wait_rdv(n);
            chk("sweep_data", phy_rd_data, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
